// File: rtl/instr_encoder_if.sv
// Request/memory-write bundle between a program loader and instr_encoder.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. While req_valid is high and req_ready is low the
// request fields are not sampled and may change freely. The im_* side is a
// plain write strobe: im_addr/im_wdata are meaningful only while im_we is high.
interface instr_encoder_if #(
    parameter int AW = 7
);
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_op;
    logic [4:0]    req_rs;
    logic [4:0]    req_rt;
    logic [4:0]    req_rd;
    logic [25:0]   req_imm;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          err;

    // Loader side: drives requests, observes writes and status.
    modport master (
        output req_valid, req_op, req_rs, req_rt, req_rd, req_imm,
        input  req_ready, im_we, im_addr, im_wdata, count, full, err
    );

    // Encoder side.
    modport slave (
        input  req_valid, req_op, req_rs, req_rt, req_rd, req_imm,
        output req_ready, im_we, im_addr, im_wdata, count, full, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Assembles MIPS-subset instruction words from a mnemonic code plus fields
// and writes them to consecutive instruction-memory words starting at 0.
module instr_encoder #(
    parameter int IM_DEPTH = 128,
    parameter int AW       = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    instr_encoder_if.slave  bus,
    output logic [0:0]      state_dbg
);
    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        legal;
    logic [31:0] word;
    logic [AW:0] count_q;

    assign bus.full     = (state == S_FULL);
    assign bus.req_ready = ~bus.full & ~clr & ~rst;
    assign bus.count    = count_q;
    assign accept       = bus.req_valid & bus.req_ready;
    assign state_dbg    = state;

    // Mnemonic decode and word assembly; illegal codes produce no word.
    always_comb begin
        logic [5:0] funct;
        logic [5:0] opcode;
        logic [4:0] rt_f;
        logic [4:0] rd_f;
        logic       is_r;
        logic       is_j;
        funct  = 6'b0;
        opcode = 6'b0;
        rt_f   = bus.req_rt;
        rd_f   = bus.req_rd;
        is_r   = 1'b0;
        is_j   = 1'b0;
        legal  = 1'b1;
        word   = 32'b0;
        case (bus.req_op)
            5'd0:  begin is_r = 1'b1; funct = 6'b100000; end
            5'd1:  begin is_r = 1'b1; funct = 6'b100010; end
            5'd2:  begin is_r = 1'b1; funct = 6'b100100; end
            5'd3:  begin is_r = 1'b1; funct = 6'b100101; end
            5'd4:  begin is_r = 1'b1; funct = 6'b101010; end
            5'd5:  begin is_r = 1'b1; funct = 6'b101011; end
            5'd6:  begin is_r = 1'b1; funct = 6'b100001; end
            5'd7:  begin is_r = 1'b1; funct = 6'b100011; end
            5'd8:  begin is_r = 1'b1; funct = 6'b100111; end
            5'd9:  begin is_r = 1'b1; funct = 6'b001000; rt_f = 5'd0; rd_f = 5'd0; end
            5'd10: begin is_r = 1'b1; funct = 6'b001001; rt_f = 5'd0; end
            5'd11: opcode = 6'b001000;
            5'd12: opcode = 6'b001101;
            5'd13: opcode = 6'b100011;
            5'd14: opcode = 6'b101011;
            5'd15: opcode = 6'b000100;
            5'd16: opcode = 6'b000101;
            5'd17: opcode = 6'b001100;
            5'd18: opcode = 6'b001010;
            5'd19: begin is_j = 1'b1; opcode = 6'b000010; end
            5'd20: begin is_j = 1'b1; opcode = 6'b000011; end
            default: legal = 1'b0;
        endcase
        if (is_r)
            word = {6'b0, bus.req_rs, rt_f, rd_f, 5'b0, funct};
        else if (is_j)
            word = {opcode, bus.req_imm};
        else if (legal)
            word = {opcode, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
    end

    // FILL/FULL next state: FULL is entered on the write that takes count to depth.
    always_comb begin
        state_next = state;
        if (clr)
            state_next = S_FILL;
        else if (state == S_FILL && accept && legal &&
                 count_q == (AW+1)'(IM_DEPTH - 1))
            state_next = S_FULL;
    end

    // State register, write port, count and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_FILL;
            count_q      <= '0;
            bus.err      <= 1'b0;
            bus.im_we    <= 1'b0;
            bus.im_addr  <= '0;
            bus.im_wdata <= '0;
        end else begin
            state <= state_next;
            if (clr) begin
                count_q   <= '0;
                bus.err   <= 1'b0;
                bus.im_we <= 1'b0;
            end else begin
                bus.im_we <= 1'b0;
                if (accept) begin
                    if (legal) begin
                        bus.im_we    <= 1'b1;
                        bus.im_addr  <= count_q[AW-1:0];
                        bus.im_wdata <= word;
                        count_q      <= count_q + 1'b1;
                    end else begin
                        bus.err <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;
    localparam int IM_DEPTH = 128;
    localparam int AW       = 7;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [0:0] state_dbg;
    int         checks;
    int         failures;

    instr_encoder_if #(.AW(AW)) bus ();

    instr_encoder #(.IM_DEPTH(IM_DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Driver: called at a falling edge; presents a request, waits for ready,
    // lets it transfer on the next rising edge and returns at the falling edge
    // after, where the resulting write is visible.
    task automatic issue(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [25:0] imm);
        int budget;
        budget        = 20;
        bus.req_op    = op;
        bus.req_rs    = rs;
        bus.req_rt    = rt;
        bus.req_rd    = rd;
        bus.req_imm   = imm;
        bus.req_valid = 1'b1;
        #1;
        while (!bus.req_ready && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (!bus.req_ready)
            check("ready_timeout", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic expect_write(input string tag, input int addr, input logic [31:0] data);
        check({tag, "_we"},   32'(bus.im_we), 32'd1);
        check({tag, "_addr"}, 32'(bus.im_addr), 32'(addr));
        check({tag, "_data"}, bus.im_wdata, data);
    endtask

    task automatic do_clear();
        idle();
        clr = 1'b1;
        #1;
        check("clr_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        clr           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_rs    = '0;
        bus.req_rt    = '0;
        bus.req_rd    = '0;
        bus.req_imm   = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_we",    32'(bus.im_we), 32'd0);
        check("rst_addr",  32'(bus.im_addr), 32'd0);
        check("rst_wdata", bus.im_wdata, 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_full",  32'(bus.full), 32'd0);
        check("rst_err",   32'(bus.err), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        // add then addi back-to-back.
        issue(5'd0, 5'd1, 5'd2, 5'd3, 26'd0);
        expect_write("add", 0, 32'h0022_1820);
        issue(5'd11, 5'd0, 5'd1, 5'd0, 26'd5);
        expect_write("addi", 1, 32'h2001_0005);
        idle();
        @(negedge clk);
        check("idle_we",    32'(bus.im_we), 32'd0);
        check("idle_hold",  32'(bus.im_addr), 32'd1);
        check("count_two",  32'(bus.count), 32'd2);
        do_clear();
        check("clr_count",  32'(bus.count), 32'd0);

        // Loads/stores, upper imm bits ignored on I-type.
        issue(5'd13, 5'd1, 5'd2, 5'd0, 26'd4);
        expect_write("lw", 0, 32'h8C22_0004);
        issue(5'd14, 5'd29, 5'd5, 5'd7, 26'h2A5_FFFC);
        expect_write("sw", 1, 32'hAFA5_FFFC);

        // Jumps and R-type field forcing.
        issue(5'd9, 5'd31, 5'd7, 5'd9, 26'd0);
        expect_write("jr", 2, 32'h03E0_0008);
        issue(5'd19, 5'd3, 5'd4, 5'd5, 26'h10);
        expect_write("j", 3, 32'h0800_0010);
        issue(5'd20, 5'd0, 5'd0, 5'd0, 26'h3FF_FFFF);
        expect_write("jal", 4, 32'h0FFF_FFFF);
        issue(5'd10, 5'd31, 5'd7, 5'd31, 26'd0);
        expect_write("jalr", 5, 32'h03E0_F809);
        issue(5'd8, 5'd4, 5'd5, 5'd6, 26'd0);
        expect_write("nor", 6, 32'h0085_3027);
        idle();
        @(negedge clk);
        check("count_seven", 32'(bus.count), 32'd7);
        do_clear();

        // Illegal code between two legal requests.
        issue(5'd0, 5'd1, 5'd2, 5'd3, 26'd0);
        expect_write("pre_ill", 0, 32'h0022_1820);
        issue(5'd25, 5'd1, 5'd1, 5'd1, 26'd1);
        check("ill_we",    32'(bus.im_we), 32'd0);
        check("ill_err",   32'(bus.err), 32'd1);
        check("ill_count", 32'(bus.count), 32'd1);
        issue(5'd12, 5'd2, 5'd3, 5'd0, 26'h00FF);
        expect_write("ori", 1, 32'h3443_00FF);
        check("err_sticky", 32'(bus.err), 32'd1);
        do_clear();
        check("err_cleared", 32'(bus.err), 32'd0);

        // Fill the whole memory with valid held high.
        for (int i = 0; i < IM_DEPTH; i++) begin
            issue(5'd11, 5'd0, 5'd1, 5'd0, 26'(i));
            expect_write("fill", i, 32'h2001_0000 | 32'(i));
        end
        check("full_set",     32'(bus.full), 32'd1);
        check("full_ready",   32'(bus.req_ready), 32'd0);
        check("full_count",   32'(bus.count), 32'd128);
        bus.req_op  = 5'd19;
        bus.req_imm = 26'h123;
        repeat (3) @(negedge clk);
        check("stall_we",     32'(bus.im_we), 32'd0);
        check("stall_count",  32'(bus.count), 32'd128);
        check("stall_ready",  32'(bus.req_ready), 32'd0);
        do_clear();
        check("refill_count", 32'(bus.count), 32'd0);
        check("refill_full",  32'(bus.full), 32'd0);
        issue(5'd19, 5'd0, 5'd0, 5'd0, 26'h123);
        expect_write("after_clr", 0, 32'h0800_0123);

        // Reset while a write is pending.
        issue(5'd0, 5'd1, 5'd2, 5'd3, 26'd0);
        check("pending_we", 32'(bus.im_we), 32'd1);
        rst = 1'b1;
        #1;
        check("async_we",    32'(bus.im_we), 32'd0);
        check("async_count", 32'(bus.count), 32'd0);
        check("async_ready", 32'(bus.req_ready), 32'd0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        issue(5'd1, 5'd4, 5'd5, 5'd6, 26'd0);
        expect_write("post_rst", 0, 32'h0085_3022);
        idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
